// File: rtl/ysyx_23060124_exu_mc.sv
// Multi-cycle execute unit: RV32I ALU, branch compare/target, iterative RV32M multiply/divide.
// Valid/ready handshakes on both sides; results are registered and held until taken downstream.
module ysyx_23060124_exu_mc #(
  parameter int unsigned XLEN     = 32,
  parameter bit          FAST_MUL = 1'b0,
  parameter bit          HAS_MDU  = 1'b1
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [1:0]      i_src_sel,
  input  logic [3:0]      i_alu_op,
  input  logic [3:0]      i_mdu_op,
  input  logic [2:0]      i_brch_op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_res,
  output logic            o_brch_taken,
  output logic [XLEN-1:0] o_brch_target,
  output logic            o_busy
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [3:0] MDU_MUL = 4'd1, MDU_MULH = 4'd2, MDU_MULHSU = 4'd3, MDU_MULHU = 4'd4,
                         MDU_DIV = 4'd5, MDU_DIVU = 4'd6, MDU_REM = 4'd7, MDU_REMU = 4'd8;
  localparam logic [2:0] BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3, BR_BGE = 3'd4,
                         BR_BLTU = 3'd5, BR_BGEU = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t state;

  logic [CW-1:0]   cnt;
  logic [3:0]      mop;
  logic [XLEN-1:0] work_hi, work_lo, divs, dividend;
  logic            neg_q, neg_r, div0;

  logic            accept, mdu_op_in, is_mul_in, mdu_iter, fast_mul, brch_taken;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [3:0]      alu_op_eff;
  logic [XLEN-1:0] op_a, op_b, alu_res, mag_a, mag_b, fast_res, mdu_res;
  logic [XLEN-1:0] nxt_hi, nxt_lo, quo, rem;
  logic [2*XLEN-1:0] fprod, prod;
  logic [XLEN:0]   mul_sum, div_r, div_d;

  assign o_ready = ~i_flush & ((state == S_IDLE) | ((state == S_DONE) & i_ready));
  assign accept  = i_valid & o_ready;

  assign mdu_op_in  = i_mdu_op inside {[MDU_MUL:MDU_REMU]};
  assign is_mul_in  = i_mdu_op inside {[MDU_MUL:MDU_MULHU]};
  assign mdu_iter   = HAS_MDU && mdu_op_in && !(FAST_MUL && is_mul_in);
  assign fast_mul   = HAS_MDU && FAST_MUL && is_mul_in;
  assign alu_op_eff = (!HAS_MDU && mdu_op_in) ? ALU_ADD : i_alu_op;

  always_comb begin
    op_a = i_src1;
    op_b = i_src2;
    case (i_src_sel)
      2'd1:    op_b = i_imm;
      2'd2:    begin op_a = i_pc; op_b = XLEN'(4); end
      2'd3:    begin op_a = i_pc; op_b = i_imm;    end
      default: ;
    endcase
  end

  always_comb begin
    alu_res = op_a + op_b;
    case (alu_op_eff)
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << op_b[CW-1:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> op_b[CW-1:0];
      ALU_SRA:  alu_res = $signed(op_a) >>> op_b[CW-1:0];
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  ;
    endcase
  end

  always_comb begin
    brch_taken = 1'b0;
    case (i_brch_op)
      BR_BEQ:  brch_taken = i_src1 == i_src2;
      BR_BNE:  brch_taken = i_src1 != i_src2;
      BR_BLT:  brch_taken = $signed(i_src1) <  $signed(i_src2);
      BR_BGE:  brch_taken = $signed(i_src1) >= $signed(i_src2);
      BR_BLTU: brch_taken = i_src1 <  i_src2;
      BR_BGEU: brch_taken = i_src1 >= i_src2;
      default: ;
    endcase
  end

  // Iterative MDU works on magnitudes; the sign is reapplied on the last step.
  assign a_sgn = i_mdu_op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  assign b_sgn = i_mdu_op inside {MDU_MULH, MDU_DIV, MDU_REM};
  assign a_neg = a_sgn & i_src1[XLEN-1];
  assign b_neg = b_sgn & i_src2[XLEN-1];
  assign mag_a = a_neg ? -i_src1 : i_src1;
  assign mag_b = b_neg ? -i_src2 : i_src2;

  assign fprod    = {{XLEN{a_neg}}, i_src1} * {{XLEN{b_neg}}, i_src2};
  assign fast_res = (i_mdu_op == MDU_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];

  // Multiply: {work_hi,work_lo} is the shift-add product register, divs the multiplicand.
  // Divide: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, divs} : '0);
    div_r   = {work_hi, work_lo[XLEN-1]};
    div_d   = div_r - {1'b0, divs};
    if (mop inside {[MDU_MUL:MDU_MULHU]}) begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], work_lo[XLEN-1:1]};
    end else if (!div_d[XLEN]) begin
      nxt_hi = div_d[XLEN-1:0];
      nxt_lo = {work_lo[XLEN-2:0], 1'b1};
    end else begin
      nxt_hi = div_r[XLEN-1:0];
      nxt_lo = {work_lo[XLEN-2:0], 1'b0};
    end
    prod = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
    quo  = div0 ? '1 : (neg_q ? -nxt_lo : nxt_lo);
    rem  = div0 ? dividend : (neg_r ? -nxt_hi : nxt_hi);
    case (mop)
      MDU_MUL:                        mdu_res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: mdu_res = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              mdu_res = quo;
      MDU_REM, MDU_REMU:              mdu_res = rem;
      default:                        mdu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      mop           <= '0;
      work_hi       <= '0;
      work_lo       <= '0;
      divs          <= '0;
      dividend      <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      div0          <= 1'b0;
      o_valid       <= 1'b0;
      o_busy        <= 1'b0;
      o_res         <= '0;
      o_brch_taken  <= 1'b0;
      o_brch_target <= '0;
    end else if (i_flush) begin
      state   <= S_IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else if (accept) begin
      o_brch_taken  <= brch_taken;
      o_brch_target <= i_pc + i_imm;
      cnt           <= '0;
      mop           <= i_mdu_op;
      work_hi       <= '0;
      work_lo       <= is_mul_in ? mag_b : mag_a;
      divs          <= is_mul_in ? mag_a : mag_b;
      dividend      <= i_src1;
      neg_q         <= a_neg ^ b_neg;
      neg_r         <= a_neg;
      div0          <= i_src2 == '0;
      if (mdu_iter) begin
        state   <= S_CALC;
        o_busy  <= 1'b1;
        o_valid <= 1'b0;
      end else begin
        state   <= S_DONE;
        o_valid <= 1'b1;
        o_res   <= fast_mul ? fast_res : alu_res;
      end
    end else begin
      case (state)
        S_CALC: begin
          work_hi <= nxt_hi;
          work_lo <= nxt_lo;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) begin
            state   <= S_DONE;
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
            o_res   <= mdu_res;
          end
        end
        S_DONE: if (i_ready) begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
